xt_rr_bus_arbiter: RTL

XT_RR_BUS_ARBITER -- requirements
Module: xt_rr_bus_arbiter

---
 rtl/xt_bus_arb_pkg.sv | 46 ++++
 rtl/xt_rr_channel.sv | 152 +++++++++++++++
 rtl/xt_rr_bus_arbiter.sv | 81 ++++++++
 3 files changed

// File: rtl/xt_bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xt_bus_arb_pkg
// Brief    : Shared helpers for the round-robin bus arbiter: index-width
//            calculation and the single-cycle cyclic round-robin picker.
// Revision : 1.0 - initial release
// ============================================================================
package xt_bus_arb_pkg;

    // Widest request vector the picker handles
    localparam int c_max_devices = 32;

    // Result of a round-robin search
    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } rr_pick_t;

    // Index width for n masters; a single master still gets a 1-bit index
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // First set bit of req scanning cyclically from start over n entries.
    // start may equal n (wraps to 0). Fully unrolled, so it resolves in one cycle.
    function automatic rr_pick_t rr_pick(input logic [c_max_devices-1:0] req,
                                         input logic [31:0]              start,
                                         input logic [31:0]              n);
        rr_pick_t    res;
        logic [31:0] j;
        res = '0;
        for (int i = 0; i < c_max_devices; i++) begin
            j = start + 32'(i);
            if (j >= n) begin
                j = j - n;
            end
            if ((32'(i) < n) && !res.valid && req[j[4:0]]) begin
                res.valid = 1'b1;
                res.idx   = j[4:0];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xt_rr_channel.sv
`default_nettype none
// ============================================================================
// Module   : xt_rr_channel
// Brief    : Single-channel round-robin arbiter with hold counter, timeout
//            preemption and a force-grant input used to break deadlocks.
// Revision : 1.0 - initial release
// ============================================================================
module xt_rr_channel
    import xt_bus_arb_pkg::*;
#(
    parameter int DEVICE_NUM     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [DEVICE_NUM-1:0]               req,
    input  logic                                force_valid,
    input  logic [idx_width(DEVICE_NUM)-1:0]    force_idx,
    output logic [DEVICE_NUM-1:0]               grant,
    output logic [idx_width(DEVICE_NUM)-1:0]    grant_idx,
    output logic                                busy,
    output logic                                timeout
);

    localparam int c_idx_w = idx_width(DEVICE_NUM);
    localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit c_preempt_en = (TIMEOUT_CYCLES > 0);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_pre =
        (TIMEOUT_CYCLES > 0) ? c_cnt_w'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [c_idx_w-1:0] c_last_rst = c_idx_w'(DEVICE_NUM - 1);

    logic [DEVICE_NUM-1:0] r_grant;
    logic [c_idx_w-1:0]    r_idx;
    logic                  r_busy;
    logic [c_idx_w-1:0]    r_last;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_timeout;

    logic [31:0]           w_req_ext;
    logic [31:0]           w_req_ex_ext;
    logic [DEVICE_NUM-1:0] w_req_ex;
    logic [31:0]           w_start;
    logic                  w_owner_req;
    rr_pick_t              w_pick;
    rr_pick_t              w_pick_ex;

    logic                  w_take;
    logic [c_idx_w-1:0]    w_take_idx;
    logic                  w_change;
    logic [DEVICE_NUM-1:0] w_nxt_grant;
    logic [c_idx_w-1:0]    w_nxt_idx;
    logic                  w_nxt_busy;
    logic [c_idx_w-1:0]    w_nxt_last;
    logic [c_cnt_w-1:0]    w_nxt_cnt;
    logic                  w_nxt_timeout;

    // Requests from everyone except the current owner, for preemption
    assign w_req_ex    = req & ~r_grant;
    // Owner still wants the bus (grant is one-hot of the owner while busy)
    assign w_owner_req = |(req & r_grant);
    assign w_start     = {{(32 - c_idx_w){1'b0}}, r_last} + 32'd1;

    // Zero-pad request vectors to the picker's fixed width
    generate
        if (DEVICE_NUM < 32) begin : g_pad
            assign w_req_ext    = {{(32 - DEVICE_NUM){1'b0}}, req};
            assign w_req_ex_ext = {{(32 - DEVICE_NUM){1'b0}}, w_req_ex};
        end else begin : g_nopad
            assign w_req_ext    = req;
            assign w_req_ex_ext = w_req_ex;
        end
    endgenerate

    assign w_pick    = rr_pick(w_req_ext,    w_start, 32'(DEVICE_NUM));
    assign w_pick_ex = rr_pick(w_req_ex_ext, w_start, 32'(DEVICE_NUM));

    // Next-owner selection: force > release > timeout preemption > hold
    always_comb begin
        w_take        = 1'b0;
        w_take_idx    = '0;
        w_change      = 1'b0;
        w_nxt_grant   = r_grant;
        w_nxt_idx     = r_idx;
        w_nxt_busy    = r_busy;
        w_nxt_last    = r_last;
        w_nxt_timeout = 1'b0;
        if (force_valid) begin
            w_take     = 1'b1;
            w_take_idx = force_idx;
        end else if (!r_busy) begin
            if (w_pick.valid) begin
                w_take     = 1'b1;
                w_take_idx = w_pick.idx[c_idx_w-1:0];
            end
        end else if (!w_owner_req) begin
            if (w_pick.valid) begin
                w_take     = 1'b1;
                w_take_idx = w_pick.idx[c_idx_w-1:0];
            end else begin
                // Go idle; index is left pointing at the last owner
                w_nxt_grant = '0;
                w_nxt_busy  = 1'b0;
                w_change    = 1'b1;
            end
        end else if (c_preempt_en && (r_cnt == c_cnt_pre) && w_pick_ex.valid) begin
            w_take        = 1'b1;
            w_take_idx    = w_pick_ex.idx[c_idx_w-1:0];
            w_nxt_timeout = 1'b1;
        end
        if (w_take) begin
            w_nxt_grant = DEVICE_NUM'(1) << w_take_idx;
            w_nxt_idx   = w_take_idx;
            w_nxt_busy  = 1'b1;
            w_nxt_last  = w_take_idx;
            w_change    = 1'b1;
        end
        if (w_change) begin
            w_nxt_cnt = '0;
        end else if (r_busy && (r_cnt != c_cnt_max)) begin
            w_nxt_cnt = r_cnt + 1'b1;
        end else begin
            w_nxt_cnt = r_cnt;
        end
    end

    // Channel state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant   <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_last    <= c_last_rst;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_grant   <= w_nxt_grant;
            r_idx     <= w_nxt_idx;
            r_busy    <= w_nxt_busy;
            r_last    <= w_nxt_last;
            r_cnt     <= w_nxt_cnt;
            r_timeout <= w_nxt_timeout;
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_idx;
    assign busy      = r_busy;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: rtl/xt_rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : xt_rr_bus_arbiter
// Brief    : Independent read/write round-robin arbiters with cross-channel
//            deadlock breaking (read channel handed to the write owner).
// Revision : 1.0 - initial release
// ============================================================================
module xt_rr_bus_arbiter
    import xt_bus_arb_pkg::*;
#(
    parameter int DEVICE_NUM     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DEVICE_NUM-1:0]            read_req,
    input  logic [DEVICE_NUM-1:0]            write_req,
    output logic [DEVICE_NUM-1:0]            read_grant,
    output logic [DEVICE_NUM-1:0]            write_grant,
    output logic [idx_width(DEVICE_NUM)-1:0] read_grant_idx,
    output logic [idx_width(DEVICE_NUM)-1:0] write_grant_idx,
    output logic                             read_busy,
    output logic                             write_busy,
    output logic                             read_timeout,
    output logic                             write_timeout,
    output logic                             deadlock_clr
);

    logic w_deadlock;
    logic r_deadlock_clr;

    // Each owner waits on the other's channel. Grants are one-hot of the
    // owners while busy, so index lookups reduce to vector ANDs.
    assign w_deadlock = read_busy && write_busy
                        && (read_grant != write_grant)
                        && (|(read_req & write_grant))
                        && (|(write_req & read_grant));

    xt_rr_channel #(
        .DEVICE_NUM     (DEVICE_NUM),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_read_ch (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (read_req),
        .force_valid (w_deadlock),
        .force_idx   (write_grant_idx),
        .grant       (read_grant),
        .grant_idx   (read_grant_idx),
        .busy        (read_busy),
        .timeout     (read_timeout)
    );

    xt_rr_channel #(
        .DEVICE_NUM     (DEVICE_NUM),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_write_ch (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (write_req),
        .force_valid (1'b0),
        .force_idx   ('0),
        .grant       (write_grant),
        .grant_idx   (write_grant_idx),
        .busy        (write_busy),
        .timeout     (write_timeout)
    );

    // One-cycle pulse aligned with the forced read grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_deadlock_clr <= 1'b0;
        end else begin
            r_deadlock_clr <= w_deadlock;
        end
    end

    assign deadlock_clr = r_deadlock_clr;

endmodule
`default_nettype wire
